// File: rtl/wb_commit_unit.sv
// Writeback commit: WB pipeline register, exception/interrupt resolution,
// the CP0 write-back bus, the pipeline flush/redirect and the GPR write port.
module wb_commit_unit #(
    parameter logic [31:0] EX_VECTOR  = 32'hBFC0_0380,
    parameter int          FLUSH_HOLD = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ms_to_ws_valid,
    output logic          ws_allowin,
    input  logic [31:0]   ms_pc,
    input  logic          ms_bd,
    input  logic          ms_ex,
    input  logic [4:0]    ms_excode,
    input  logic [31:0]   ms_badvaddr,
    input  logic          ms_mtc0,
    input  logic          ms_mfc0,
    input  logic          ms_eret,
    input  logic [4:0]    ms_c0_addr,
    input  logic [31:0]   ms_rt_value,
    input  logic          ms_rf_we,
    input  logic [4:0]    ms_rf_waddr,
    input  logic [31:0]   ms_result,
    input  logic          c0_status_ie,
    input  logic          c0_status_exl,
    input  logic [7:0]    c0_status_im,
    input  logic [7:0]    c0_cause_ip,
    input  logic [31:0]   c0_rdata,
    input  logic [31:0]   c0_epc,
    output logic [109:0]  wb_to_cp0_register_bus,
    output logic          flush,
    output logic [31:0]   flush_pc,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata
);

    typedef enum logic {
        S_RUN,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;

    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_bd;
    logic        r_ex;
    logic [4:0]  r_excode;
    logic [31:0] r_badvaddr;
    logic        r_mtc0;
    logic        r_mfc0;
    logic        r_eret;
    logic [4:0]  r_c0_addr;
    logic [31:0] r_rt_value;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_result;

    logic        w_int_req;
    logic        w_ex;
    logic        w_up_ex;
    logic        w_mtc0_we;
    logic        w_eret_flush;
    logic        w_flush;
    logic [4:0]  w_excode;
    logic [31:0] w_badvaddr;
    logic        w_bd;
    logic [31:0] w_pc;
    logic [4:0]  w_c0_waddr;
    logic [31:0] w_c0_wdata;

    assign ws_allowin = (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_flush) begin
                        r_state <= S_HOLD;
                        r_cnt   <= 3'(FLUSH_HOLD);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == 3'd1)
                        r_state <= S_RUN;
                    r_cnt <= r_cnt - 3'd1;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // A flushed cycle still accepts MEM's fields, but never their valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_bd       <= 1'b0;
            r_ex       <= 1'b0;
            r_excode   <= 5'd0;
            r_badvaddr <= 32'd0;
            r_mtc0     <= 1'b0;
            r_mfc0     <= 1'b0;
            r_eret     <= 1'b0;
            r_c0_addr  <= 5'd0;
            r_rt_value <= 32'd0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_result   <= 32'd0;
        end else begin
            if (!ws_allowin || w_flush)
                r_valid <= 1'b0;
            else
                r_valid <= ms_to_ws_valid;
            if (ws_allowin && ms_to_ws_valid) begin
                r_pc       <= ms_pc;
                r_bd       <= ms_bd;
                r_ex       <= ms_ex;
                r_excode   <= ms_excode;
                r_badvaddr <= ms_badvaddr;
                r_mtc0     <= ms_mtc0;
                r_mfc0     <= ms_mfc0;
                r_eret     <= ms_eret;
                r_c0_addr  <= ms_c0_addr;
                r_rt_value <= ms_rt_value;
                r_rf_we    <= ms_rf_we;
                r_rf_waddr <= ms_rf_waddr;
                r_result   <= ms_result;
            end
        end
    end

    assign w_int_req = c0_status_ie && !c0_status_exl
                    && (|(c0_status_im & c0_cause_ip));

    // Interrupt outranks an upstream exception and reports excode 0.
    assign w_ex         = r_valid && (w_int_req || r_ex);
    assign w_up_ex      = w_ex && !w_int_req;
    assign w_excode     = w_up_ex ? r_excode : 5'd0;
    assign w_badvaddr   = w_up_ex ? r_badvaddr : 32'd0;
    assign w_bd         = r_valid && r_bd;
    assign w_pc         = r_valid ? r_pc : 32'd0;
    assign w_mtc0_we    = r_valid && r_mtc0 && !w_ex;
    assign w_eret_flush = r_valid && r_eret && !w_ex;
    assign w_c0_waddr   = (r_valid && (r_mtc0 || r_mfc0))
                        ? r_c0_addr : 5'd0;
    assign w_c0_wdata   = w_mtc0_we ? r_rt_value : 32'd0;

    assign wb_to_cp0_register_bus = {
        w_ex, w_excode, w_badvaddr, w_bd, w_pc,
        w_mtc0_we, w_c0_waddr, w_c0_wdata, w_eret_flush
    };

    assign w_flush  = w_ex || w_eret_flush;
    assign flush    = w_flush;
    assign flush_pc = w_ex         ? EX_VECTOR :
                      w_eret_flush ? c0_epc    : 32'd0;

    assign rf_we    = r_valid && r_rf_we && !w_ex;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_mfc0 ? c0_rdata : r_result;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed literal cases, then random traffic
// compared every cycle against a behavioural commit model.
module tb_wb_commit_unit;

    localparam int          HOLD = 3;
    localparam logic [31:0] EXV  = 32'hBFC0_0380;

    logic          clk;
    logic          reset;
    logic          ms_to_ws_valid;
    logic          ws_allowin;
    logic [31:0]   ms_pc;
    logic          ms_bd;
    logic          ms_ex;
    logic [4:0]    ms_excode;
    logic [31:0]   ms_badvaddr;
    logic          ms_mtc0;
    logic          ms_mfc0;
    logic          ms_eret;
    logic [4:0]    ms_c0_addr;
    logic [31:0]   ms_rt_value;
    logic          ms_rf_we;
    logic [4:0]    ms_rf_waddr;
    logic [31:0]   ms_result;
    logic          c0_status_ie;
    logic          c0_status_exl;
    logic [7:0]    c0_status_im;
    logic [7:0]    c0_cause_ip;
    logic [31:0]   c0_rdata;
    logic [31:0]   c0_epc;
    logic [109:0]  bus;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;

    wb_commit_unit #(.EX_VECTOR(EXV), .FLUSH_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex),
        .ms_excode(ms_excode), .ms_badvaddr(ms_badvaddr),
        .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0), .ms_eret(ms_eret),
        .ms_c0_addr(ms_c0_addr), .ms_rt_value(ms_rt_value),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
        .ms_result(ms_result),
        .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
        .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip),
        .c0_rdata(c0_rdata), .c0_epc(c0_epc),
        .wb_to_cp0_register_bus(bus), .flush(flush),
        .flush_pc(flush_pc), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [109:0] got,
                       input logic [109:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // Model: the instruction sitting in WB plus cycles left refusing input.
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        bd;
        logic        ex;
        logic [4:0]  code;
        logic [31:0] bva;
        logic        mtc0;
        logic        mfc0;
        logic        eret;
        logic [4:0]  c0a;
        logic [31:0] rt;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] res;
    } slot_t;

    typedef struct {
        logic         allow;
        logic [109:0] bus;
        logic         flush;
        logic [31:0]  fpc;
        logic         we;
        logic [4:0]   wa;
        logic [31:0]  wd;
    } exp_t;

    slot_t m;
    int    hold_left;

    function automatic exp_t model_out();
        exp_t  e;
        logic  irq, tint, texc, ex, mt, er;
        irq  = c0_status_ie && !c0_status_exl
            && ((c0_status_im & c0_cause_ip) != 8'd0);
        tint = m.v && irq;
        texc = m.v && !irq && m.ex;
        ex   = tint || texc;
        mt   = m.v && m.mtc0 && !ex;
        er   = m.v && m.eret && !ex;
        e.allow = (hold_left == 0);
        e.bus = {ex,
                 texc ? m.code : 5'd0,
                 texc ? m.bva : 32'd0,
                 m.v ? m.bd : 1'b0,
                 m.v ? m.pc : 32'd0,
                 mt,
                 (m.v && (m.mtc0 || m.mfc0)) ? m.c0a : 5'd0,
                 mt ? m.rt : 32'd0,
                 er};
        e.flush = ex || er;
        e.fpc   = ex ? EXV : (er ? c0_epc : 32'd0);
        e.we    = m.v && m.we && !ex;
        e.wa    = m.wa;
        e.wd    = m.mfc0 ? c0_rdata : m.res;
        return e;
    endfunction

    initial begin
        m = '{default: '0};
        hold_left = 0;
    end

    always @(posedge clk) begin
        exp_t e;
        e = model_out();
        if (reset) begin
            m = '{default: '0};
            hold_left = 0;
        end else if (hold_left > 0) begin
            hold_left = hold_left - 1;
            m.v = 1'b0;
        end else begin
            if (ms_to_ws_valid) begin
                m.pc = ms_pc;  m.bd = ms_bd;  m.ex = ms_ex;
                m.code = ms_excode;  m.bva = ms_badvaddr;
                m.mtc0 = ms_mtc0;  m.mfc0 = ms_mfc0;
                m.eret = ms_eret;  m.c0a = ms_c0_addr;
                m.rt = ms_rt_value;  m.we = ms_rf_we;
                m.wa = ms_rf_waddr;  m.res = ms_result;
            end
            m.v = ms_to_ws_valid && !e.flush;
            if (e.flush) hold_left = HOLD;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = model_out();
            chk("m_allowin", 110'(ws_allowin), 110'(e.allow));
            chk("m_bus", bus, e.bus);
            chk("m_flush", 110'(flush), 110'(e.flush));
            chk("m_flush_pc", 110'(flush_pc), 110'(e.fpc));
            chk("m_rf_we", 110'(rf_we), 110'(e.we));
            chk("m_rf_waddr", 110'(rf_waddr), 110'(e.wa));
            chk("m_rf_wdata", 110'(rf_wdata), 110'(e.wd));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic clr_ms();
        ms_to_ws_valid = 0;  ms_pc = 0;  ms_bd = 0;  ms_ex = 0;
        ms_excode = 0;  ms_badvaddr = 0;  ms_mtc0 = 0;  ms_mfc0 = 0;
        ms_eret = 0;  ms_c0_addr = 0;  ms_rt_value = 0;  ms_rf_we = 0;
        ms_rf_waddr = 0;  ms_result = 0;
    endtask

    task automatic clr_c0();
        c0_status_ie = 0;  c0_status_exl = 0;  c0_status_im = 0;
        c0_cause_ip = 0;  c0_rdata = 0;  c0_epc = 0;
    endtask

    task automatic wait_hold();
        @(posedge clk); #1;
        clr_ms();
        clr_c0();
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        clr_ms();
        clr_c0();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_allowin", 110'(ws_allowin), 110'd1);
        chk("rst_bus", bus, 110'd0);
        chk("rst_flush", 110'(flush), 110'd0);
        chk("rst_rf_we", 110'(rf_we), 110'd0);

        // ALU commit
        @(posedge clk); #1;
        ms_to_ws_valid = 1;  ms_pc = 32'hBFC0_0100;
        ms_rf_we = 1;  ms_rf_waddr = 5'd3;  ms_result = 32'h1234;
        @(posedge clk); #1;
        clr_ms();
        @(negedge clk);
        chk("alu_rf_we", 110'(rf_we), 110'd1);
        chk("alu_waddr", 110'(rf_waddr), 110'd3);
        chk("alu_wdata", 110'(rf_wdata), 110'h1234);
        chk("alu_bus", bus, 110'(32'hBFC0_0100) << 39);
        chk("alu_flush", 110'(flush), 110'd0);

        // address-error load in a delay slot
        @(posedge clk); #1;
        ms_to_ws_valid = 1;  ms_ex = 1;  ms_excode = 5'h04;
        ms_badvaddr = 32'h3;  ms_bd = 1;  ms_pc = 32'hBFC0_0200;
        ms_rf_we = 1;  ms_rf_waddr = 5'd7;
        @(posedge clk); #1;
        clr_ms();
        ms_to_ws_valid = 1;  ms_pc = 32'hBFC0_0300;
        ms_rf_we = 1;  ms_rf_waddr = 5'd8;
        @(negedge clk);
        chk("ade_ex", 110'(bus[109]), 110'd1);
        chk("ade_excode", 110'(bus[108:104]), 110'h04);
        chk("ade_bva", 110'(bus[103:72]), 110'h3);
        chk("ade_bd", 110'(bus[71]), 110'd1);
        chk("ade_pc", 110'(bus[70:39]), 110'hBFC0_0200);
        chk("ade_flush", 110'(flush), 110'd1);
        chk("ade_fpc", 110'(flush_pc), 110'hBFC0_0380);
        chk("ade_rf_we", 110'(rf_we), 110'd0);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            chk("hold_allowin", 110'(ws_allowin), 110'd0);
            chk("hold_rf_we", 110'(rf_we), 110'd0);
        end
        @(negedge clk);
        chk("run_allowin", 110'(ws_allowin), 110'd1);
        chk("run_nocapture", 110'(rf_we), 110'd0);
        ms_to_ws_valid = 0;

        // interrupt beats an upstream exception on an MTC0
        @(posedge clk); #1;
        ms_to_ws_valid = 1;  ms_mtc0 = 1;  ms_ex = 1;  ms_excode = 5'h0C;
        ms_badvaddr = 32'hDEAD_BEEF;  ms_c0_addr = 5'd12;
        ms_rt_value = 32'h5;  ms_pc = 32'hBFC0_0400;
        @(posedge clk); #1;
        clr_ms();
        c0_status_ie = 1;  c0_status_im = 8'h80;  c0_cause_ip = 8'h80;
        @(negedge clk);
        chk("int_ex", 110'(bus[109]), 110'd1);
        chk("int_excode", 110'(bus[108:104]), 110'd0);
        chk("int_bva", 110'(bus[103:72]), 110'd0);
        chk("int_mtc0_we", 110'(bus[38]), 110'd0);
        chk("int_flush", 110'(flush), 110'd1);
        chk("int_fpc", 110'(flush_pc), 110'hBFC0_0380);
        wait_hold();

        // ERET with the interrupt masked by EXL
        @(posedge clk); #1;
        ms_to_ws_valid = 1;  ms_eret = 1;  ms_pc = 32'hBFC0_0500;
        @(posedge clk); #1;
        clr_ms();
        c0_status_ie = 1;  c0_status_exl = 1;
        c0_status_im = 8'hFF;  c0_cause_ip = 8'hFF;
        c0_epc = 32'hBFC0_0444;
        @(negedge clk);
        chk("eret_bit0", 110'(bus[0]), 110'd1);
        chk("eret_ex", 110'(bus[109]), 110'd0);
        chk("eret_flush", 110'(flush), 110'd1);
        chk("eret_fpc", 110'(flush_pc), 110'hBFC0_0444);
        wait_hold();

        // MTC0 then MFC0 back to back
        @(posedge clk); #1;
        ms_to_ws_valid = 1;  ms_mtc0 = 1;  ms_c0_addr = 5'd11;
        ms_rt_value = 32'h50;
        @(posedge clk); #1;
        clr_ms();
        ms_to_ws_valid = 1;  ms_mfc0 = 1;  ms_c0_addr = 5'd9;
        ms_rf_we = 1;  ms_rf_waddr = 5'd4;  ms_rt_value = 32'h99;
        @(negedge clk);
        chk("mtc0_we", 110'(bus[38]), 110'd1);
        chk("mtc0_addr", 110'(bus[37:33]), 110'd11);
        chk("mtc0_wdata", 110'(bus[32:1]), 110'h50);
        @(posedge clk); #1;
        clr_ms();
        c0_rdata = 32'h77;
        @(negedge clk);
        chk("mfc0_wdata", 110'(rf_wdata), 110'h77);
        chk("mfc0_rf_we", 110'(rf_we), 110'd1);
        chk("mfc0_c0_wdata", 110'(bus[32:1]), 110'd0);
        chk("mfc0_addr", 110'(bus[37:33]), 110'd9);

        // reset in the middle of HOLD
        @(posedge clk); #1;
        clr_c0();
        ms_to_ws_valid = 1;  ms_ex = 1;  ms_excode = 5'h05;
        @(posedge clk); #1;
        clr_ms();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rsthold_allowin", 110'(ws_allowin), 110'd1);
        chk("rsthold_flush", 110'(flush), 110'd0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            reset          = ($urandom_range(0, 99) == 0);
            ms_to_ws_valid = ($urandom_range(0, 3) != 0);
            ms_pc          = $urandom;
            ms_bd          = 1'($urandom);
            ms_ex          = ($urandom_range(0, 7) == 0);
            ms_excode      = 5'($urandom);
            ms_badvaddr    = $urandom;
            ms_mtc0        = ($urandom_range(0, 5) == 0);
            ms_mfc0        = ($urandom_range(0, 5) == 0);
            ms_eret        = ($urandom_range(0, 9) == 0);
            ms_c0_addr     = 5'($urandom);
            ms_rt_value    = $urandom;
            ms_rf_we       = 1'($urandom);
            ms_rf_waddr    = 5'($urandom);
            ms_result      = $urandom;
            c0_status_ie   = 1'($urandom);
            c0_status_exl  = ($urandom_range(0, 3) == 0);
            c0_status_im   = 8'($urandom);
            c0_cause_ip    = 8'(32'd1 << $urandom_range(0, 15));
            c0_rdata       = $urandom;
            c0_epc         = $urandom;
        end
        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
